sound_tone_generator: RTL and testbench

Downstream consumer of the collision-sound edge detector. Takes the `goodColl` and `badColl` request levels and plays a fixed-length square-wave tone on the speaker pin. A good collision plays a high tone and a bad collision plays a low tone. A bad request pre-empts a good tone, and status outputs let the game FSM see when a tone is playing or has finished.

---
 rtl/sound_tone_generator_if.sv | 31 +++
 rtl/sound_tone_generator.sv | 130 +++++++++++++
 tb/tb_sound_tone_generator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sound_tone_generator_if.sv
// Request and status signals between the game logic and the tone generator.
// The master drives tone requests and mute; the slave reports speaker and status.
interface sound_tone_generator_if;
    logic       goodColl;
    logic       badColl;
    logic       mute_i;
    logic       sound_o;
    logic       busy_o;
    logic [1:0] tone_o;
    logic       done_o;

    modport master (
        output goodColl,
        output badColl,
        output mute_i,
        input  sound_o,
        input  busy_o,
        input  tone_o,
        input  done_o
    );

    modport slave (
        input  goodColl,
        input  badColl,
        input  mute_i,
        output sound_o,
        output busy_o,
        output tone_o,
        output done_o
    );
endinterface

// File: rtl/sound_tone_generator.sv
// Fixed-length square-wave tone player: high tone on a good collision, low tone
// on a bad one. A bad request pre-empts a good tone; done_o pulses on natural expiry.
module sound_tone_generator #(
    parameter int unsigned GOOD_HALF = 5682,
    parameter int unsigned BAD_HALF  = 22727,
    parameter int unsigned DURATION  = 1000000,
    parameter int unsigned HALF_W    = 16,
    parameter int unsigned DUR_W     = 20
) (
    input  logic                   clk,
    input  logic                   nRst,
    sound_tone_generator_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGood = 2'b01,
        StBad  = 2'b10
    } state_e;

    localparam logic [HALF_W-1:0] GoodReload = HALF_W'(GOOD_HALF - 1);
    localparam logic [HALF_W-1:0] BadReload  = HALF_W'(BAD_HALF - 1);
    localparam logic [DUR_W-1:0]  DurReload  = DUR_W'(DURATION - 1);

    state_e            state_q, state_d;
    logic [HALF_W-1:0] hcnt_q, hcnt_d;
    logic [DUR_W-1:0]  dcnt_q, dcnt_d;
    logic              tone_q, tone_d;
    logic              done_q, done_d;

    // Reload value of the half-period counter for the tone currently playing.
    logic [HALF_W-1:0] half_reload;

    // Pick the half-period of the active tone.
    always_comb begin
        half_reload = (state_q == StBad) ? BadReload : GoodReload;
    end

    // Next-state logic: tone entry, square-wave toggling, expiry and pre-emption.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        dcnt_d  = dcnt_q;
        tone_d  = tone_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Bad has priority when both requests arrive together.
                if (bus.badColl) begin
                    state_d = StBad;
                    hcnt_d  = BadReload;
                    dcnt_d  = DurReload;
                    tone_d  = 1'b1;
                end else if (bus.goodColl) begin
                    state_d = StGood;
                    hcnt_d  = GoodReload;
                    dcnt_d  = DurReload;
                    tone_d  = 1'b1;
                end
            end

            StGood, StBad: begin
                // Square wave: toggle at the end of each half-period.
                if (hcnt_q == '0) begin
                    tone_d = ~tone_q;
                    hcnt_d = half_reload;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end

                // Duration: expire after the last cycle of the tone.
                if (dcnt_q == '0) begin
                    state_d = StIdle;
                    hcnt_d  = '0;
                    tone_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end

                // A bad request restarts as a fresh bad tone and wins over expiry.
                if (state_q == StGood && bus.badColl) begin
                    state_d = StBad;
                    hcnt_d  = BadReload;
                    dcnt_d  = DurReload;
                    tone_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                hcnt_d  = '0;
                dcnt_d  = '0;
                tone_d  = 1'b0;
            end
        endcase
    end

    // State and counter registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            dcnt_q  <= '0;
            tone_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
        end
    end

    // Outputs: mute gates only the speaker, and that is the only combinational path.
    always_comb begin
        bus.sound_o = tone_q & ~bus.mute_i;
        bus.busy_o  = (state_q != StIdle);
        bus.done_o  = done_q;
        unique case (state_q)
            StGood:  bus.tone_o = 2'b01;
            StBad:   bus.tone_o = 2'b10;
            default: bus.tone_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_sound_tone_generator.sv
// Bench for sound_tone_generator: directed scenarios followed by random requests,
// every cycle compared against a tone model based on age within the current tone.
module tb_sound_tone_generator;

    localparam int unsigned GoodHalf = 2;
    localparam int unsigned BadHalf  = 3;
    localparam int unsigned Dur      = 12;

    logic clk;
    logic nRst;
    int   checks;
    int   fails;
    int   cyc;

    // Model: 0 idle, 1 good, 2 bad; age counts cycles since the tone started.
    int   m_tone;
    int   m_age;
    int   m_done;

    sound_tone_generator_if bus ();

    sound_tone_generator #(
        .GOOD_HALF (GoodHalf),
        .BAD_HALF  (BadHalf),
        .DURATION  (Dur),
        .HALF_W    (4),
        .DUR_W     (5)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int exp_sound();
        int half;
        if (m_tone == 0) return 0;
        half = (m_tone == 1) ? GoodHalf : BadHalf;
        if (bus.mute_i) return 0;
        return ((m_age / half) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_tone = 0;
        m_age  = 0;
        m_done = 0;
    endtask

    task automatic model_step();
        if (m_tone == 0) begin
            m_done = 0;
            if (bus.badColl) begin
                m_tone = 2; m_age = 0;
            end else if (bus.goodColl) begin
                m_tone = 1; m_age = 0;
            end
        end else if (m_tone == 1 && bus.badColl) begin
            m_tone = 2; m_age = 0; m_done = 0;
        end else if (m_age == Dur - 1) begin
            m_tone = 0; m_age = 0; m_done = 1;
        end else begin
            m_age++;
            m_done = 0;
        end
    endtask

    task automatic check_all();
        chk("sound", {1'b0, bus.sound_o}, 2'(exp_sound()));
        chk("busy",  {1'b0, bus.busy_o},  (m_tone != 0) ? 2'd1 : 2'd0);
        chk("tone",  bus.tone_o,          2'(m_tone));
        chk("done",  {1'b0, bus.done_o},  2'(m_done));
    endtask

    // One clock: model follows the DUT edge, outputs checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        if (nRst) model_step();
        else model_reset();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sound"}, {1'b0, bus.sound_o}, 2'd0);
        chk({tag, "_busy"},  {1'b0, bus.busy_o},  2'd0);
        chk({tag, "_tone"},  bus.tone_o,          2'd0);
        chk({tag, "_done"},  {1'b0, bus.done_o},  2'd0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        cyc    = 0;
        model_reset();

        // Reset with requests high: everything stays at zero.
        nRst         = 1'b0;
        bus.goodColl = 1'b1;
        bus.badColl  = 1'b1;
        bus.mute_i   = 1'b0;
        @(negedge clk);
        check_zero("rst_hold");
        repeat (3) tick();
        bus.goodColl = 1'b0;
        bus.badColl  = 1'b0;
        nRst         = 1'b1;
        repeat (3) tick();

        // Single good pulse.
        for (int c = 0; c < 15; c++) begin
            bus.goodColl = (c == 0);
            tick();
            if (c == 12) chk("good_done_t13", {1'b0, bus.done_o}, 2'd1);
            if (c == 1)  chk("good_tone_t2", bus.tone_o, 2'b01);
        end

        // Both requests together: bad wins.
        for (int c = 0; c < 15; c++) begin
            bus.goodColl = (c == 0);
            bus.badColl  = (c == 0);
            tick();
            if (c == 0) chk("both_tone_t1", bus.tone_o, 2'b10);
        end

        // Good at t0 pre-empted by bad at t5.
        for (int c = 0; c < 20; c++) begin
            bus.goodColl = (c == 0);
            bus.badColl  = (c == 5);
            tick();
            if (c == 12) chk("preempt_no_done_t13", {1'b0, bus.done_o}, 2'd0);
            if (c == 17) chk("preempt_done_t18", {1'b0, bus.done_o}, 2'd1);
        end

        // Held good request: back-to-back tones with one idle cycle between.
        for (int c = 0; c < 45; c++) begin
            bus.goodColl = (c < 30);
            bus.badColl  = 1'b0;
            tick();
            if (c == 25) chk("held_busy_t26", {1'b0, bus.busy_o}, 2'd0);
            if (c == 26) chk("held_busy_t27", {1'b0, bus.busy_o}, 2'd1);
        end

        // Mute during a bad tone.
        for (int c = 0; c < 15; c++) begin
            bus.badColl = (c == 0);
            bus.mute_i  = (c >= 2 && c <= 8);
            tick();
            if (c == 3) chk("mute_tone_t4", bus.tone_o, 2'b10);
        end
        bus.mute_i = 1'b0;

        // Reset pulse in the middle of a good tone.
        for (int c = 0; c < 6; c++) begin
            bus.goodColl = (c == 0);
            tick();
        end
        #2;
        nRst = 1'b0;
        #1;
        model_reset();
        check_zero("rst_mid");
        @(negedge clk);
        nRst = 1'b1;
        for (int c = 0; c < 16; c++) tick();

        // Random requests and mute.
        for (int c = 0; c < 600; c++) begin
            bus.goodColl = ($urandom_range(0, 9) == 0);
            bus.badColl  = ($urandom_range(0, 19) == 0);
            bus.mute_i   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
